// File: rtl/dmux_pkg.sv
// Shared definitions for the buffered stream demultiplexer: select width helper,
// drop counter width and the channel-slice macro used to pack channel heads.
`ifndef DMUX_PKG_SV
`define DMUX_PKG_SV

`define DMUX_CH_SLICE(k, w) ((k)*(w)) +: (w)

package dmux_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Select field width for a given channel count; never narrower than one bit.
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

`endif

// File: rtl/dmux_chan_fifo.sv
// Per-channel FIFO: registered storage with a combinational head, extra-MSB
// pointers so full and empty are distinguishable without a separate counter.
module dmux_chan_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign not_empty = ~empty;
  assign head_data = mem_q[rd_q[AW-1:0]];

  // Upstream already refuses beats for a full channel; guard again so the
  // FIFO can never overwrite unread data on its own.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is cleared on reset so the packed head bus is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/dmux_stream_router.sv
// Routes a valid/ready stream to one of NCH buffered channels (or all of them
// on broadcast) and counts beats discarded for out-of-range selects.
module dmux_stream_router
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 8,
  parameter int DEPTH = 4,
  parameter int SELW  = sel_width(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NCH*WIDTH-1:0]  out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH-1:0]        ch_full,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  sel_err
);

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic [NCH-1:0]        full_w;
  logic [NCH-1:0]        nempty_w;
  logic [NCH-1:0]        push_w;
  logic                  sel_ok;
  logic                  sel_full;
  logic                  all_clear;
  logic                  accept;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  sel_err_q, sel_err_d;

  assign sel_ok    = ({1'b0, in_sel} < NCH_L);
  assign all_clear = ~|full_w;

  // Looked up by comparison rather than indexing so an out-of-range select
  // never addresses past the end of full_w.
  always_comb begin
    sel_full = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) sel_full = full_w[k];
    end
  end

  // Only fullness feeds in_ready: a pop on a full channel never opens a
  // same-cycle push slot.
  always_comb begin
    if (in_bcast)    in_ready = all_clear;
    else if (sel_ok) in_ready = ~sel_full;
    else             in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_ok;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign push_w[gi] = accept & (in_bcast | (in_sel == SELW'(gi)));

      dmux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_w[gi]),
        .push_data (in_data),
        .pop       (out_ready[gi]),
        .head_data (out_data[`DMUX_CH_SLICE(gi, WIDTH)]),
        .not_empty (nempty_w[gi]),
        .full      (full_w[gi])
      );
    end
  endgenerate

  always_comb begin
    drop_d    = drop_q;
    sel_err_d = sel_err_q | drop;
    if (drop && (drop_q != DROP_CNT_MAX)) drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      drop_q    <= drop_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = nempty_w;
  assign ch_full   = full_w;
  assign drop_cnt  = drop_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_dmux_stream_router.sv
// Scoreboarded bench for dmux_stream_router: directed beats push expectations,
// a negedge monitor compares channel state and popped heads against them.
module tb_dmux_stream_router;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default configuration (8 channels)
  logic [15:0]  a_in_data = '0;
  logic [2:0]   a_in_sel = '0;
  logic         a_in_bcast = 1'b0;
  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic [127:0] a_out_data;
  logic [7:0]   a_out_valid;
  logic [7:0]   a_out_ready = 8'hFF;
  logic [7:0]   a_ch_full;
  logic [15:0]  a_drop_cnt;
  logic         a_sel_err;

  // DUT B: 6 channels, so selects 6 and 7 are out of range
  logic [15:0]  b_in_data = '0;
  logic [2:0]   b_in_sel = '0;
  logic         b_in_bcast = 1'b0;
  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [95:0]  b_out_data;
  logic [5:0]   b_out_valid;
  logic [5:0]   b_out_ready = 6'h3F;
  logic [5:0]   b_ch_full;
  logic [15:0]  b_drop_cnt;
  logic         b_sel_err;

  dmux_stream_router #(.WIDTH(16), .NCH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .ch_full(a_ch_full), .drop_cnt(a_drop_cnt), .sel_err(a_sel_err)
  );

  dmux_stream_router #(.WIDTH(16), .NCH(6), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ch_full(b_ch_full), .drop_cnt(b_drop_cnt), .sel_err(b_sel_err)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [8][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: channel occupancy and every popped head against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (a_out_valid[k] !== (exp_q[k].size() != 0)) begin
          errors++;
          $display("FAIL mon_valid ch%0d got %b want %b", k, a_out_valid[k], exp_q[k].size() != 0);
        end
        checks++;
        if (a_ch_full[k] !== (exp_q[k].size() == 4)) begin
          errors++;
          $display("FAIL mon_full ch%0d got %b want %b", k, a_ch_full[k], exp_q[k].size() == 4);
        end
        if (a_out_valid[k] && a_out_ready[k] && exp_q[k].size() != 0) begin
          checks++;
          if (a_out_data[k*16 +: 16] !== exp_q[k][0]) begin
            errors++;
            $display("FAIL mon_data ch%0d got %h want %h", k, a_out_data[k*16 +: 16], exp_q[k][0]);
          end
          void'(exp_q[k].pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [2:0] s, input logic b);
    bit ok = 1'b0;
    a_in_data = d; a_in_sel = s; a_in_bcast = b; a_in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout sel %0d got ready 0 want 1", s);
      a_in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (b) for (int k = 0; k < 8; k++) exp_q[k].push_back(d);
      else exp_q[s].push_back(d);
      #1;
      a_in_valid = 1'b0; a_in_bcast = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'h0);
    check("rst_ch_full", 32'(a_ch_full), 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic routing
    send(16'hA5A5, 3'd5, 1'b0);
    check("basic_valid", 32'(a_out_valid), 32'h20);
    check("basic_data", 32'(a_out_data[5*16 +: 16]), 32'hA5A5);
    idle(3);
    check("basic_single", 32'(a_out_valid), 32'h0);

    // Fill and backpressure on channel 2
    a_out_ready[2] = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'(i), 3'd2, 1'b0);
    check("fill_full2", 32'(a_ch_full[2]), 32'h1);
    a_in_sel = 3'd2; #1 check("fill_rdy_sel2", 32'(a_in_ready), 32'h0);
    a_in_sel = 3'd3; #1 check("fill_rdy_sel3", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    fork
      send(16'd5, 3'd2, 1'b0);
      begin repeat (3) @(posedge clk); #1 a_out_ready[2] = 1'b1; end
    join
    idle(8);
    check("fill_drained", 32'(a_out_valid), 32'h0);

    // Broadcast
    send(16'h1234, 3'd0, 1'b1);
    check("bcast_valid", 32'(a_out_valid), 32'hFF);
    for (int k = 0; k < 8; k++)
      check($sformatf("bcast_data%0d", k), 32'(a_out_data[k*16 +: 16]), 32'h1234);
    idle(3);

    // Broadcast blocked by a full channel 7: no partial push anywhere
    a_out_ready[7] = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h7000 + 16'(i), 3'd7, 1'b0);
    check("bfull_full7", 32'(a_ch_full[7]), 32'h1);
    a_in_data = 16'hBEEF; a_in_bcast = 1'b1; a_in_valid = 1'b1;
    #1 check("bfull_ready", 32'(a_in_ready), 32'h0);
    idle(3);
    check("bfull_nopush", 32'(a_out_valid), 32'h80);
    a_in_valid = 1'b0; a_in_bcast = 1'b0;
    a_out_ready[7] = 1'b1;
    idle(6);

    // Concurrent push/pop on channel 0 holding two entries
    a_out_ready[0] = 1'b0;
    send(16'h0100, 3'd0, 1'b0);
    send(16'h0101, 3'd0, 1'b0);
    a_out_ready[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(16'h0102 + 16'(i), 3'd0, 1'b0);
      check("conc_count2", 32'(exp_q[0].size()), 32'd2);
      check("conc_notfull", 32'(a_ch_full[0]), 32'h0);
    end
    idle(4);
    check("conc_drained", 32'(a_out_valid), 32'h0);

    // Out-of-range selects on the 6-channel instance
    b_in_data = 16'hDEAD; b_in_sel = 3'd7; b_in_valid = 1'b1;
    #1 check("oor_ready", 32'(b_in_ready), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    check("oor_nowrite", 32'(b_out_valid), 32'h0);
    check("oor_drop2", 32'(b_drop_cnt), 32'd2);
    check("oor_selerr", 32'(b_sel_err), 32'h1);
    b_in_data = 16'h0B01; b_in_sel = 3'd1; b_in_valid = 1'b1;
    @(posedge clk); #1 b_in_valid = 1'b0;
    check("oor_valid_beat", 32'(b_out_valid), 32'h02);
    check("oor_valid_data", 32'(b_out_data[1*16 +: 16]), 32'h0B01);
    check("oor_drop_held", 32'(b_drop_cnt), 32'd2);
    check("oor_selerr_held", 32'(b_sel_err), 32'h1);
    idle(2);

    // Reset mid-traffic with channel 1 full
    a_out_ready[1] = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h1100 + 16'(i), 3'd1, 1'b0);
    a_in_data = 16'h3333; a_in_sel = 3'd3; a_in_valid = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    #1;
    check("mrst_out_valid", 32'(a_out_valid), 32'h0);
    check("mrst_ch_full", 32'(a_ch_full), 32'h0);
    check("mrst_drop_a", 32'(a_drop_cnt), 32'h0);
    check("mrst_selerr_a", 32'(a_sel_err), 32'h0);
    check("mrst_drop_b", 32'(b_drop_cnt), 32'h0);
    check("mrst_selerr_b", 32'(b_sel_err), 32'h0);
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    a_out_ready = 8'hFF;
    a_in_sel = 3'd3; a_in_bcast = 1'b0;
    #1 check("mrst_ready3", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    send(16'h3C3C, 3'd3, 1'b0);
    check("post_rst_valid", 32'(a_out_valid), 32'h08);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux_stream_router.md
Name: dmux_stream_router

Overview:
- Parametrised, buffered successor to the combinational 8-way 16-bit demultiplexer.
- Routes a valid/ready input stream to one of NCH output channels selected per beat, or to all channels at once in broadcast mode.
- Each output channel has its own DEPTH-entry FIFO, so a stalled consumer does not block the others.
- Sits between the CPU/memory write path and downstream peripheral or register-file ports; it also reports beats dropped for out-of-range selects.

Parameters:
- WIDTH, 16, data width in bits per beat (>=1).
- NCH, 8, number of output channels (2..64; need not be a power of two).
- DEPTH, 4, entries per channel FIFO (power of two, >=2).
- SELW, $clog2(NCH), width of the select field (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  input beat.
- in_sel  in  SELW  destination channel index.
- in_bcast  in  1  1 = write the beat to every channel; in_sel is ignored.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- out_data  out  NCH*WIDTH  packed channel heads; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  NCH  channel k holds at least one entry.
- out_ready  in  NCH  channel k consumer pops its head.
- ch_full  out  NCH  channel k FIFO holds DEPTH entries.
- drop_cnt  out  16  saturating count of dropped beats.
- sel_err  out  1  sticky flag: an out-of-range select was seen.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous assert, synchronous deassert at the system level, active low.
  - Reset clears all FIFO pointers and counts, so out_valid=0 and ch_full=0.
  - Reset also sets drop_cnt=0 and sel_err=0.
  - out_data is don't-care while out_valid=0, but must be X-free after reset; reset clears storage.
- in_ready is combinational and independent of in_valid:
  - bcast=1: in_ready = no channel full (AND of ~ch_full).
  - bcast=0 and in_sel<NCH: in_ready = ~ch_full[in_sel].
  - bcast=0 and in_sel>=NCH: in_ready = 1.
- A beat is accepted on a clock edge when in_valid & in_ready.
- Push rules:
  - Normal beat: pushed into FIFO in_sel.
  - Broadcast beat: pushed into every FIFO in the same cycle.
  - Out-of-range beat: consumed and discarded. drop_cnt increments, saturating at 16'hFFFF, and sel_err is set and held until reset.
- Latency:
  - A beat accepted at edge N appears at the channel head with out_valid=1 after edge N. This is 1 cycle; there is no combinational in-to-out path.
- Pop: at each edge where out_valid[k] & out_ready[k], channel k advances its read pointer. out_ready on an empty channel is ignored.
- Simultaneous push and pop on the same channel:
  - Not full: both happen; the count is unchanged.
  - Full: the push is refused because in_ready was low. A pop while full does not enable a same-cycle push (no ready-through-pop path).
- Pointers: log2(DEPTH)+1 bits each; wrap modulo 2*DEPTH. full = MSBs differ and LSBs equal; empty = pointers equal.
- Channels are independent. A full channel blocks only beats addressed to it, plus all broadcasts.
- Protocol assumption: once in_valid rises, the upstream holds in_data, in_sel and in_bcast stable until acceptance. The block does not check this.
- Reset mid-operation: all queued beats are discarded immediately. in_ready is valid from the first cycle after rst_n deasserts.

Decomposition:
- Shared package/header dmux_pkg:
  - localparam helper for the SELW computation.
  - DROP_CNT_W = 16.
  - Channel-slice macro for the out_data packing.
- One sub-module, dmux_chan_fifo (WIDTH, DEPTH):
  - Inputs: push, push_data, pop.
  - Outputs: head_data, not_empty, full.
- The top module instantiates NCH copies in a generate loop and holds the select decode, broadcast logic, in_ready logic and the drop counter.

Test Plan:
- Reset check: assert rst_n=0 mid-traffic. Require out_valid=0, ch_full=0, drop_cnt=0 and sel_err=0 asynchronously (before the next edge), and in_ready=1 for in_sel=3 after release.
- Basic routing (defaults): send 16'hA5A5 with sel=5, out_ready all 1. Require out_valid=8'b0010_0000 one cycle after acceptance, channel 5 data = 16'hA5A5, and a single beat only.
- Fill and backpressure:
  - Hold out_ready[2]=0 and send 5 beats to sel=2.
  - Require 4 accepted, ch_full[2]=1, and in_ready=0 for sel=2 while in_ready=1 for sel=3.
  - Release out_ready[2]; require FIFO order 1,2,3,4 and then the 5th beat.
- Broadcast:
  - Send in_bcast=1, data 16'h1234. Require all 8 out_valid high with data 16'h1234 on every channel.
  - With channel 7 full, require in_ready=0 for broadcast and no partial push.
- Out-of-range: NCH=6 (SELW=3), send sel=7 twice. Require in_ready=1, no channel written, drop_cnt=2 and sel_err=1, held after further valid traffic.
- Concurrent push/pop: keep channel 0 at 2 entries with a simultaneous push and pop every cycle for 20 cycles. Require the count stays at 2, data arrives in order, and no beat is lost or duplicated.
